// File: rtl/dbns_converter_param.sv
// -----------------------------------------------------------------------------
// dbns_converter_param
//
// Greedy double-base (2,3) converter. An unsigned WIDTH-bit operand is
// accepted, then candidate terms 3^a * 2^b are tried one per clock, with
// a running from A_MAX down to 0 (outer) and b from B_MAX down to 0 (inner).
// Every candidate that fits in the remaining difference is subtracted and
// its bit is set in a one-hot-per-term bitmap.
//
// Bitmap index i = (B_MAX-b) + (B_MAX+1)*(A_MAX-a): bit 0 is the largest
// term 3^A_MAX*2^B_MAX and bit NBITS-1 is the term 1.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds valid (and data) until
// that edge. The result side holds out_valid and all result outputs
// stable until out_ready is seen.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   in_valid       operand valid
//   in_ready       converter can accept an operand (IDLE only)
//   in_data        unsigned operand
//   cfg_max_terms  term limit, sampled on accept; 0 = unlimited
//   out_valid      result valid
//   out_ready      consumer accepts result
//   dbns           term bitmap
//   term_cnt       number of bits set in dbns
//   residual       operand minus sum of selected terms
//   exact          residual == 0
// -----------------------------------------------------------------------------
module dbns_converter_param #(
   parameter  int WIDTH = 16,
   parameter  int A_MAX = 5,
   parameter  int B_MAX = 5,
   localparam int NBITS = (A_MAX + 1) * (B_MAX + 1),
   localparam int CW    = $clog2(NBITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CW-1:0]    cfg_max_terms,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NBITS-1:0] dbns,
   output logic [CW-1:0]    term_cnt,
   output logic [WIDTH-1:0] residual,
   output logic             exact
);

   // Bit length of 3^A_MAX; terms need that plus B_MAX bits to stay exact.
   function automatic int pow3_bits();
      longint unsigned p;
      int              n;
      p = 1;
      n = 0;
      for (int k = 0; k < A_MAX; k++) p = p * 3;
      while (p != 0) begin
         n++;
         p = p >> 1;
      end
      return n;
   endfunction

   localparam int TW = pow3_bits() + B_MAX;              // exact term width
   localparam int MW = (WIDTH > TW) ? WIDTH : TW;        // compare width
   localparam int AW = (A_MAX > 0) ? $clog2(A_MAX + 1) : 1;
   localparam int BW = (B_MAX > 0) ? $clog2(B_MAX + 1) : 1;
   localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

   function automatic logic [TW-1:0] pow3_f(input int k);
      logic [TW-1:0] p;
      p = TW'(1);
      for (int j = 0; j < k; j++) p = p * TW'(3);
      return p;
   endfunction

   // Constant table of powers of three; the power of two is a shift.
   logic [TW-1:0] pow3_tab [A_MAX+1];
   for (genvar k = 0; k <= A_MAX; k++) begin : g_pow3
      assign pow3_tab[k] = pow3_f(k);
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q,     state_d;
   logic [WIDTH-1:0]   diff_q,      diff_d;
   logic [CW-1:0]      limit_q,     limit_d;
   logic [NBITS-1:0]   dbns_q,      dbns_d;
   logic [CW-1:0]      cnt_q,       cnt_d;
   logic [AW-1:0]      a_q,         a_d;
   logic [BW-1:0]      b_q,         b_d;
   logic [IW-1:0]      idx_q,       idx_d;
   logic               exact_q,     exact_d;
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;

   logic [TW-1:0]      term;
   logic [MW-1:0]      term_ext;
   logic [MW-1:0]      diff_ext;
   logic [MW-1:0]      diff_sub;
   logic               hit;
   logic [WIDTH-1:0]   diff_new;
   logic [CW-1:0]      cnt_new;
   logic               last_cand;

   always_comb begin
      term      = pow3_tab[a_q] << b_q;
      term_ext  = MW'(term);
      diff_ext  = MW'(diff_q);
      hit       = (diff_ext >= term_ext);
      diff_sub  = diff_ext - term_ext;
      // When hit, diff_sub <= diff_q so it always fits back into WIDTH.
      diff_new  = hit ? WIDTH'(diff_sub) : diff_q;
      cnt_new   = cnt_q + CW'(hit);
      last_cand = (a_q == '0) && (b_q == '0);

      state_d   = state_q;
      diff_d    = diff_q;
      limit_d   = limit_q;
      dbns_d    = dbns_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      exact_d   = exact_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               diff_d  = in_data;
               limit_d = cfg_max_terms;
               dbns_d  = '0;
               cnt_d   = '0;
               a_d     = AW'(A_MAX);
               b_d     = BW'(B_MAX);
               idx_d   = '0;
               exact_d = 1'b0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            diff_d = diff_new;
            cnt_d  = cnt_new;
            if (hit) dbns_d[idx_q] = 1'b1;
            if ((diff_new == '0) || last_cand ||
                ((limit_q != '0) && (cnt_new == limit_q))) begin
               exact_d = (diff_new == '0);
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IW'(1);
               if (b_q == '0) begin
                  b_d = BW'(B_MAX);
                  a_d = a_q - AW'(1);
               end else begin
                  b_d = b_q - BW'(1);
               end
            end
         end
         S_DONE: begin
            // out_ready only counts once the result is actually presented.
            if (out_valid_q && out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Registered handshake outputs. out_valid rises one cycle after the
      // scan finishes, giving the k+1 cycle latency for k candidates.
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_q == S_DONE) && (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         diff_q      <= '0;
         limit_q     <= '0;
         dbns_q      <= '0;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         idx_q       <= '0;
         exact_q     <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         diff_q      <= diff_d;
         limit_q     <= limit_d;
         dbns_q      <= dbns_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         idx_q       <= idx_d;
         exact_q     <= exact_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign dbns      = dbns_q;
   assign term_cnt  = cnt_q;
   assign residual  = diff_q;
   assign exact     = exact_q;

endmodule

// File: tb/tb_dbns_converter_param.sv
module tb_dbns_converter_param;

   localparam int WIDTH = 16;
   localparam int NBITS = 36;
   localparam int CW    = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic [CW-1:0]    cfg_max_terms = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [NBITS-1:0] dbns;
   logic [CW-1:0]    term_cnt;
   logic [WIDTH-1:0] residual;
   logic             exact;

   int errors = 0;
   int checks = 0;

   dbns_converter_param dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .cfg_max_terms (cfg_max_terms),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .dbns          (dbns),
      .term_cnt      (term_cnt),
      .residual      (residual),
      .exact         (exact)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // One full transaction: accept, measure latency, check result, hand off.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] data,
                         input logic [CW-1:0] lim, input logic [NBITS-1:0] e_dbns,
                         input int e_cnt, input logic [WIDTH-1:0] e_res,
                         input logic e_exact, input int e_lat);
      int w;
      int lat;
      w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      in_valid      = 1'b1;
      in_data       = data;
      cfg_max_terms = lim;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"},  64'(lat),      64'(e_lat));
      check({tag, "_dbns"},     64'(dbns),     64'(e_dbns));
      check({tag, "_term_cnt"}, 64'(term_cnt), 64'(e_cnt));
      check({tag, "_residual"}, 64'(residual), 64'(e_res));
      check({tag, "_exact"},    64'(exact),    64'(e_exact));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_out_valid_drop"}, 64'(out_valid), 64'(0));
      check({tag, "_in_ready_back"},  64'(in_ready),  64'(1));
   endtask

   initial begin
      int w;

      // Reset held low: everything zero, not ready.
      repeat (3) @(negedge clk);
      check("rst_in_ready",  64'(in_ready),  64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_dbns",      64'(dbns),      64'(0));
      check("rst_term_cnt",  64'(term_cnt),  64'(0));
      check("rst_exact",     64'(exact),     64'(0));
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'(1));

      run_op("zero",     16'd0,     6'd0, 36'h000000000, 0,  16'd0,     1'b0 | 1'b1, 2);
      run_op("max_term", 16'd7776,  6'd0, 36'h000000001, 1,  16'd0,     1'b1, 2);
      run_op("two",      16'd2,     6'd0, 36'h400000000, 1,  16'd0,     1'b1, 36);
      run_op("one",      16'd1,     6'd0, 36'h800000000, 1,  16'd0,     1'b1, 37);
      run_op("ten",      16'd10,    6'd0, 36'h800800000, 2,  16'd0,     1'b1, 37);
      run_op("ten_lim1", 16'd10,    6'd1, 36'h000800000, 1,  16'd1,     1'b0, 25);
      run_op("all_ones", 16'd65535, 6'd0, 36'hFFFFFFFFF, 36, 16'd42603, 1'b0, 37);

      // Backpressure: result held while in_valid stays high with other data.
      in_valid      = 1'b1;
      in_data       = 16'd10;
      cfg_max_terms = 6'd0;
      @(negedge clk);
      in_data = 16'd5;
      w = 0;
      while (!out_valid && w < 60) begin
         @(negedge clk);
         w++;
      end
      for (int c = 0; c < 5; c++) begin
         check("bp_out_valid", 64'(out_valid), 64'(1));
         check("bp_in_ready",  64'(in_ready),  64'(0));
         check("bp_dbns",      64'(dbns),      64'(36'h800800000));
         check("bp_term_cnt",  64'(term_cnt),  64'(2));
         check("bp_exact",     64'(exact),     64'(1));
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_handoff_out_valid", 64'(out_valid), 64'(0));
      check("bp_handoff_in_ready",  64'(in_ready),  64'(1));

      // Reset in the middle of a long scan.
      in_valid = 1'b1;
      in_data  = 16'd65535;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("midscan_out_valid", 64'(out_valid), 64'(0));
      check("midscan_in_ready",  64'(in_ready),  64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready",  64'(in_ready),  64'(0));
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_dbns",      64'(dbns),      64'(0));
      check("midrst_term_cnt",  64'(term_cnt),  64'(0));
      check("midrst_residual",  64'(residual),  64'(0));
      check("midrst_exact",     64'(exact),     64'(0));
      rst = 1'b1;
      @(negedge clk);
      run_op("after_rst", 16'd10, 6'd0, 36'h800800000, 2, 16'd0, 1'b1, 37);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dbns_converter_param.md
Name: dbns_converter_param

Overview:
- Parametrised greedy double-base (2,3) number-system converter; successor to the fixed 16-bit, 6x6-exponent DBNS converter.
- Takes an unsigned WIDTH-bit operand through a valid/ready handshake.
- Scans candidate terms 3^a*2^b from largest exponent pair downward, one candidate per clock, and emits a one-hot-per-term bitmap.
- Also emits term count, residual and exactness flag. Adds an optional term-limit (approximation) mode.
- Sits in front of the DBNS multiplier datapath.

Parameters:
- WIDTH, 16, operand and residual width.
- A_MAX, 5, maximum exponent of 3.
- B_MAX, 5, maximum exponent of 2.
- NBITS, (A_MAX+1)*(B_MAX+1), derived localparam: bitmap width (36 at defaults).
- CW, $clog2(NBITS+1), derived localparam: term-count width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  converter can accept an operand.
- in_data  in  WIDTH  unsigned operand.
- cfg_max_terms  in  CW  term limit, sampled on accept; 0 = unlimited.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- dbns  out  NBITS  term bitmap.
- term_cnt  out  CW  number of bits set in dbns.
- residual  out  WIDTH  operand minus sum of selected terms.
- exact  out  1  residual == 0.

Behaviour:
- Reset: clk edge with rst=0 forces IDLE from any state, including mid-scan or DONE. All outputs go to 0 (in_ready=0 while rst=0). The in-flight operand is discarded.
- Bitmap index: i = (B_MAX-b) + (B_MAX+1)*(A_MAX-a). Index 0 is 3^A_MAX*2^B_MAX; index NBITS-1 is 1.
- Candidate order: a from A_MAX down to 0 (outer loop); b from B_MAX down to 0 (inner loop).
- State IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch diff=in_data and limit=cfg_max_terms; clear the working bitmap and count; set candidate to (A_MAX,B_MAX); go to SCAN.
- State SCAN: in_ready=0. One candidate per cycle.
  - If diff >= term: diff -= term, bit[i]=1, count+=1.
  - Go to DONE if any of these hold: updated diff == 0; candidate is (0,0); limit != 0 and updated count == limit.
  - Otherwise advance the candidate: b-1, or b=B_MAX and a-1 when b==0.
- Term arithmetic:
  - Terms are computed exactly at a width holding 3^A_MAX*2^B_MAX, independent of WIDTH.
  - A term larger than the maximum operand is simply never selected.
  - No truncation of terms to WIDTH.
- State DONE: out_valid=1; dbns, term_cnt, residual and exact are registered and held stable.
  - in_valid is ignored (in_ready=0).
  - On out_ready=1, go to IDLE. in_ready=1 the following cycle; no accept in the same cycle as result handoff.
- Latency: with k candidates evaluated (1..NBITS), out_valid is first high k+1 cycles after the accept edge. Worst case NBITS+1 (37 at defaults).
- in_data=0: single SCAN cycle, dbns=0, exact=1.
- Operand above the sum of all terms: every bit set; residual = in_data - (sum 3^a)*(sum 2^b); exact=0.

Test Plan:
- in_data=0 → out_valid 2 cycles after accept, dbns=0, term_cnt=0, residual=0, exact=1.
- in_data=7776 → dbns=36'h000000001, term_cnt=1, exact=1, latency 2.
- in_data=2 → dbns bit34 only, term_cnt=1, exact=1, latency 36. in_data=1 → bit35 only, latency 37.
- in_data=10, cfg_max_terms=0 → bits 23 and 35, term_cnt=2, exact=1. Same with cfg_max_terms=1 → bit23 only, residual=1, exact=0, latency 25.
- in_data=65535 → dbns all ones, term_cnt=36, residual=42603, exact=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 → outputs stable, in_ready=0, no accept; in_ready=1 one cycle after out_ready. Then drive rst=0 mid-scan → next edge IDLE with all outputs 0; a fresh in_data=10 then gives the correct result.
